// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

    localparam int AWIDTH_DEF = 6;
    localparam int RWIDTH_DEF = 32;

    localparam logic [31:0] NOP_INSTR = 32'b00000000000001111000000000000000;

    typedef struct packed {
        logic [RWIDTH_DEF-1:0] instr;
        logic [AWIDTH_DEF-1:0] pc;
        logic [AWIDTH_DEF-1:0] pc_plus1;
        logic                  valid;
    } if_id_t;

endpackage

// File: rtl/instruction_fetch_unit_pc.sv
// Program counter: reset value, target load, hold, and increment that wraps at 2**AWIDTH.
module program_counter
    import fetch_pkg::*;
#(
    parameter int AWIDTH   = AWIDTH_DEF,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    input  logic [AWIDTH-1:0] target,
    output logic [AWIDTH-1:0] pc,
    output logic [AWIDTH-1:0] pc_plus1
);

    // Natural modulo-2**AWIDTH wrap from the fixed width.
    assign pc_plus1 = pc + AWIDTH'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pc <= AWIDTH'(RESET_PC);
        else if (load)    pc <= target;
        else if (advance) pc <= pc_plus1;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, captures combinational imem data into IF/ID.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int AWIDTH   = AWIDTH_DEF,
    parameter int RWIDTH   = RWIDTH_DEF,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [AWIDTH-1:0] branch_target,
    output logic [AWIDTH-1:0] imem_addr,
    input  logic [RWIDTH-1:0] imem_rdata,
    output logic [RWIDTH-1:0] if_id_instr,
    output logic [AWIDTH-1:0] if_id_pc,
    output logic [AWIDTH-1:0] if_id_pc_plus1,
    output logic              if_id_valid
`ifdef FETCH_PERF_CNT_EN
   ,output logic [15:0]       fetch_count,
    output logic [15:0]       bubble_count
`endif
);

    typedef struct packed {
        logic [RWIDTH-1:0] instr;
        logic [AWIDTH-1:0] pc;
        logic [AWIDTH-1:0] pc_plus1;
        logic              valid;
    } if_id_reg_t;

    logic [AWIDTH-1:0] pc, pc_plus1;
    logic              load_bubble, load_fetch;
    if_id_reg_t        if_id_q;

    // branch_taken > flush > stall > normal
    assign load_bubble = branch_taken || flush;
    assign load_fetch  = !branch_taken && !flush && !stall;

    program_counter #(.AWIDTH(AWIDTH), .RESET_PC(RESET_PC)) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (branch_taken),
        .advance  (flush || !stall),
        .target   (branch_target),
        .pc       (pc),
        .pc_plus1 (pc_plus1)
    );

    assign imem_addr = pc;

    // A bubble keeps pc/pc_plus1 so decode still sees the last real address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_q <= '{instr: RWIDTH'(NOP_INSTR), pc: '0, pc_plus1: '0, valid: 1'b0};
        end else if (load_bubble) begin
            if_id_q.instr <= RWIDTH'(NOP_INSTR);
            if_id_q.valid <= 1'b0;
        end else if (load_fetch) begin
            if_id_q <= '{instr: imem_rdata, pc: pc, pc_plus1: pc_plus1, valid: 1'b1};
        end
    end

    assign if_id_instr    = if_id_q.instr;
    assign if_id_pc       = if_id_q.pc;
    assign if_id_pc_plus1 = if_id_q.pc_plus1;
    assign if_id_valid    = if_id_q.valid;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (load_fetch && fetch_count != 16'hFFFF)   fetch_count  <= fetch_count + 16'd1;
            if (load_bubble && bubble_count != 16'hFFFF) bubble_count <= bubble_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed vector table, async reset sequence,
// then randomized traffic against a behavioural model.
module tb_instruction_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0, flush = 1'b0, branch_taken = 1'b0;
    logic [5:0]  branch_target = '0;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [5:0]  if_id_pc, if_id_pc_plus1;
    logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count, bubble_count;
`endif

    logic [31:0] mem [64];
    assign imem_rdata = mem[imem_addr];

    always #5 clk = ~clk;

    instruction_fetch_unit #(.AWIDTH(6), .RWIDTH(32), .RESET_PC(0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .flush          (flush),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
       ,.fetch_count    (fetch_count),
        .bubble_count   (bubble_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       st, fl, br;
        logic [5:0] tgt;
        int         e_addr, e_pc, e_pp1;
        logic       e_v;
        int         e_idx;   // -1 means NOP bubble
    } vec_t;

    vec_t tbl[$];

    // Behavioural model state
    int          m_pc, m_ipc, m_ipp1, m_fc, m_bc;
    logic [31:0] m_instr;
    bit          m_v;

    task automatic check_reset_state(input string tag);
        chk({tag, "_addr"},  64'(imem_addr), 64'd0);
        chk({tag, "_valid"}, 64'(if_id_valid), 64'd0);
        chk({tag, "_instr"}, 64'(if_id_instr), 64'(NOP_INSTR));
        chk({tag, "_pc"},    64'(if_id_pc), 64'd0);
        chk({tag, "_pp1"},   64'(if_id_pc_plus1), 64'd0);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, "_fcnt"},  64'(fetch_count), 64'd0);
        chk({tag, "_bcnt"},  64'(bubble_count), 64'd0);
`endif
    endtask

    initial begin
        // Standard 10-instruction program, then a distinct filler pattern.
        mem[0] = 32'h0000_0093; mem[1] = 32'h0010_0113; mem[2] = 32'h0020_8193;
        mem[3] = 32'h0031_0233; mem[4] = 32'h0042_02B3; mem[5] = 32'h0052_8333;
        mem[6] = 32'hFE03_0EE3; mem[7] = 32'h0063_23A3; mem[8] = 32'h0073_A403;
        mem[9] = 32'h0000_006F;
        for (int i = 10; i < 64; i++) mem[i] = 32'hC0DE_0000 | 32'(i * 257);

        //        st fl br tgt   addr pc pp1 v  idx
        tbl.push_back('{0, 0, 0, 6'h00,  1,  0,  1, 1,  0});
        tbl.push_back('{0, 0, 0, 6'h15,  2,  1,  2, 1,  1});
        tbl.push_back('{0, 0, 0, 6'h00,  3,  2,  3, 1,  2});
        tbl.push_back('{0, 0, 0, 6'h00,  4,  3,  4, 1,  3});
        tbl.push_back('{1, 0, 0, 6'h2A,  4,  3,  4, 1,  3});
        tbl.push_back('{1, 0, 0, 6'h2A,  4,  3,  4, 1,  3});
        tbl.push_back('{1, 0, 0, 6'h2A,  4,  3,  4, 1,  3});
        tbl.push_back('{0, 0, 0, 6'h00,  5,  4,  5, 1,  4});
        tbl.push_back('{0, 0, 0, 6'h00,  6,  5,  6, 1,  5});
        tbl.push_back('{0, 0, 1, 6'd9,   9,  5,  6, 0, -1});
        tbl.push_back('{0, 0, 0, 6'h00, 10,  9, 10, 1,  9});
        tbl.push_back('{1, 1, 1, 6'd2,   2,  9, 10, 0, -1});
        tbl.push_back('{0, 0, 0, 6'h00,  3,  2,  3, 1,  2});
        tbl.push_back('{0, 0, 0, 6'h00,  4,  3,  4, 1,  3});
        tbl.push_back('{0, 0, 0, 6'h00,  5,  4,  5, 1,  4});
        tbl.push_back('{0, 1, 0, 6'h00,  6,  4,  5, 0, -1});
        tbl.push_back('{0, 0, 0, 6'h00,  7,  6,  7, 1,  6});
        tbl.push_back('{0, 0, 1, 6'd63, 63,  6,  7, 0, -1});
        tbl.push_back('{0, 0, 0, 6'h00,  0, 63,  0, 1, 63});
        tbl.push_back('{0, 0, 0, 6'h00,  1,  0,  1, 1,  0});

        // Reset state while rst_n is held low.
        #12;
        check_reset_state("reset");
        @(negedge clk) rst_n = 1'b1;

        // Directed table
        foreach (tbl[k]) begin
            logic [31:0] exp_instr;
`ifdef FETCH_PERF_CNT_EN
            logic [15:0] fc0, bc0;
            fc0 = fetch_count;
            bc0 = bubble_count;
`endif
            stall = tbl[k].st; flush = tbl[k].fl;
            branch_taken = tbl[k].br; branch_target = tbl[k].tgt;
            @(posedge clk); #1;
            exp_instr = (tbl[k].e_idx < 0) ? NOP_INSTR : mem[tbl[k].e_idx];
            chk($sformatf("vec%0d_addr", k),  64'(imem_addr), 64'(tbl[k].e_addr));
            chk($sformatf("vec%0d_pc", k),    64'(if_id_pc), 64'(tbl[k].e_pc));
            chk($sformatf("vec%0d_pp1", k),   64'(if_id_pc_plus1), 64'(tbl[k].e_pp1));
            chk($sformatf("vec%0d_valid", k), 64'(if_id_valid), 64'(tbl[k].e_v));
            chk($sformatf("vec%0d_instr", k), 64'(if_id_instr), 64'(exp_instr));
`ifdef FETCH_PERF_CNT_EN
            chk($sformatf("vec%0d_bcnt", k), 64'(bubble_count),
                64'(bc0) + ((tbl[k].br || tbl[k].fl) ? 64'd1 : 64'd0));
            chk($sformatf("vec%0d_fcnt", k), 64'(fetch_count),
                64'(fc0) + ((!tbl[k].br && !tbl[k].fl && !tbl[k].st) ? 64'd1 : 64'd0));
`endif
            @(negedge clk);
        end
        stall = 0; flush = 0; branch_taken = 0;

        // Async reset asserted mid-cycle during a stall.
        stall = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(negedge clk);
        stall = 1'b0;
        m_pc = 0; m_ipc = 0; m_ipp1 = 0; m_v = 0; m_instr = NOP_INSTR; m_fc = 0; m_bc = 0;
        rst_n = 1'b1;

        // Randomized run; first step is a plain fetch to confirm mem[RESET_PC] is captured.
        for (int i = 0; i < 400; i++) begin
            logic st, fl, br;
            logic [5:0] tgt;
            st  = (i == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
            fl  = (i == 0) ? 1'b0 : ($urandom_range(0, 7) == 0);
            br  = (i == 0) ? 1'b0 : ($urandom_range(0, 7) == 0);
            tgt = 6'($urandom);
            stall = st; flush = fl; branch_taken = br; branch_target = tgt;
            @(posedge clk);
            if (br) begin
                m_pc = int'(tgt); m_v = 0; m_instr = NOP_INSTR;
                if (m_bc < 65535) m_bc++;
            end else if (fl) begin
                m_pc = (m_pc + 1) % 64; m_v = 0; m_instr = NOP_INSTR;
                if (m_bc < 65535) m_bc++;
            end else if (!st) begin
                m_instr = mem[m_pc]; m_ipc = m_pc; m_ipp1 = (m_pc + 1) % 64; m_v = 1;
                m_pc = (m_pc + 1) % 64;
                if (m_fc < 65535) m_fc++;
            end
            #1;
            chk($sformatf("rnd%0d_addr", i),  64'(imem_addr), 64'(m_pc));
            chk($sformatf("rnd%0d_pc", i),    64'(if_id_pc), 64'(m_ipc));
            chk($sformatf("rnd%0d_pp1", i),   64'(if_id_pc_plus1), 64'(m_ipp1));
            chk($sformatf("rnd%0d_valid", i), 64'(if_id_valid), 64'(m_v));
            chk($sformatf("rnd%0d_instr", i), 64'(if_id_instr), 64'(m_instr));
`ifdef FETCH_PERF_CNT_EN
            chk($sformatf("rnd%0d_fcnt", i),  64'(fetch_count), 64'(m_fc));
            chk($sformatf("rnd%0d_bcnt", i),  64'(bubble_count), 64'(m_bc));
`endif
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
